// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the generic pipeline stage register.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // ST_ prefix keeps the literals distinct from the SKID build parameter.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam logic [1:0] c_occ_empty = 2'd0;
    localparam logic [1:0] c_occ_one   = 2'd1;
    localparam logic [1:0] c_occ_two   = 2'd2;

    localparam int c_ctrl_w_dec_ex = 10;
    localparam int c_ctrl_w_ex_mem = 8;
    localparam int c_ctrl_w_mem_wb = 4;

    localparam logic [c_ctrl_w_dec_ex-1:0] c_ctrl_clr_dec_ex = '0;
    localparam logic [c_ctrl_w_ex_mem-1:0] c_ctrl_clr_ex_mem = '0;
    localparam logic [c_ctrl_w_mem_wb-1:0] c_ctrl_clr_mem_wb = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Brief    : Handshake, payload, flush and counter bundle of a pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) ();

    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        occupancy_o;
    logic              clr_cnt_i;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport slave (
        input  flush_i, valid_i, ctrl_i, data_i, ready_i, clr_cnt_i,
        output ready_o, valid_o, ctrl_o, data_o, occupancy_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output flush_i, valid_i, ctrl_i, data_i, ready_i, clr_cnt_i,
        input  ready_o, valid_o, ctrl_o, data_o, occupancy_o, stall_cnt_o, flush_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Brief    : One valid/ctrl/data pipeline entry with load, clear and hold.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int                CTRL_W   = 10,
    parameter int                DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_CLR = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_clear,
    input  wire logic [CTRL_W-1:0] i_ctrl,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_valid,
    output logic      [CTRL_W-1:0] o_ctrl,
    output logic      [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Clearing forces the bubble control value; data is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_CLR;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_CLR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Parametrised pipeline stage register, optional 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 10,
    parameter int                DATA_W   = 128,
    parameter int                SKID     = 1,
    parameter logic [CTRL_W-1:0] CTRL_CLR = '0,
    parameter int                CNT_W    = 16
) (
    input wire logic         clk_i,
    input wire logic         rst_i,
    pipe_stage_reg_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_ready;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ld_ctrl;
    logic [DATA_W-1:0] w_main_ld_data;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic [1:0]        w_occ;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_in_xfer  = bus.valid_i & w_ready;
    assign w_out_xfer = w_main_valid & bus.ready_i;

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_CLR (CTRL_CLR)
    ) u_main (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ld_ctrl),
        .i_data  (w_main_ld_data),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_state_e       r_state;
        pipe_state_e       w_state_next;
        logic              w_skid_load;
        logic              w_skid_clear;
        logic              w_skid_valid;
        logic              w_from_skid;
        logic [CTRL_W-1:0] w_skid_ctrl;
        logic [DATA_W-1:0] w_skid_data;

        pipe_slot #(
            .CTRL_W   (CTRL_W),
            .DATA_W   (DATA_W),
            .CTRL_CLR (CTRL_CLR)
        ) u_skid (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_ctrl  (bus.ctrl_i),
            .i_data  (bus.data_i),
            .o_valid (w_skid_valid),
            .o_ctrl  (w_skid_ctrl),
            .o_data  (w_skid_data)
        );

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= ST_EMPTY;
            end else begin
                r_state <= w_state_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_main_load  = 1'b0;
            w_main_clear = 1'b0;
            w_skid_load  = 1'b0;
            w_skid_clear = 1'b0;
            w_from_skid  = 1'b0;
            if (bus.flush_i) begin
                w_state_next = ST_EMPTY;
                w_main_clear = 1'b1;
                w_skid_clear = 1'b1;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_xfer) begin
                            w_state_next = ST_FULL;
                            w_main_load  = 1'b1;
                        end
                    end
                    ST_FULL: begin
                        if (w_in_xfer && w_out_xfer) begin
                            w_main_load  = 1'b1;
                        end else if (w_in_xfer) begin
                            w_state_next = ST_SKID;
                            w_skid_load  = 1'b1;
                        end else if (w_out_xfer) begin
                            w_state_next = ST_EMPTY;
                            w_main_clear = 1'b1;
                        end
                    end
                    ST_SKID: begin
                        // Older skid entry moves up so ordering is preserved.
                        if (w_out_xfer) begin
                            w_state_next = ST_FULL;
                            w_main_load  = 1'b1;
                            w_from_skid  = 1'b1;
                            w_skid_clear = 1'b1;
                        end
                    end
                    default: begin
                        w_state_next = ST_EMPTY;
                        w_main_clear = 1'b1;
                        w_skid_clear = 1'b1;
                    end
                endcase
            end
        end

        assign w_ready        = (r_state != ST_SKID);
        assign w_main_ld_ctrl = w_from_skid ? w_skid_ctrl : bus.ctrl_i;
        assign w_main_ld_data = w_from_skid ? w_skid_data : bus.data_i;
        assign w_occ          = w_skid_valid ? c_occ_two :
                                (w_main_valid ? c_occ_one : c_occ_empty);
    end else begin : g_single
        assign w_ready        = bus.ready_i | ~w_main_valid;
        assign w_main_load    = ~bus.flush_i & w_in_xfer;
        assign w_main_clear   = bus.flush_i | (w_out_xfer & ~w_in_xfer);
        assign w_main_ld_ctrl = bus.ctrl_i;
        assign w_main_ld_data = bus.data_i;
        assign w_occ          = w_main_valid ? c_occ_one : c_occ_empty;
    end

    // Clear beats increment; both counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clr_cnt_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_valid && !bus.ready_i && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (bus.flush_i && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ready_o     = w_ready;
    assign bus.valid_o     = w_main_valid;
    assign bus.ctrl_o      = w_main_ctrl;
    assign bus.data_o      = w_main_data;
    assign bus.occupancy_o = w_occ;
    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Three stage variants driven in lockstep against a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int               c_cw  = 10;
    localparam int               c_dw  = 32;
    localparam logic [c_cw-1:0]  c_clr = 10'h2A5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid = 1'b0;
    logic              rdy = 1'b0;
    logic              flush = 1'b0;
    logic              clr = 1'b0;
    logic [c_cw-1:0]   ctrl = '0;
    logic [c_dw-1:0]   data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(c_cw), .DATA_W(c_dw), .CNT_W(16)) bus_s1 ();
    pipe_stage_reg_if #(.CTRL_W(c_cw), .DATA_W(c_dw), .CNT_W(16)) bus_s0 ();
    pipe_stage_reg_if #(.CTRL_W(c_cw), .DATA_W(c_dw), .CNT_W(4))  bus_c4 ();

    assign bus_s1.valid_i = valid;  assign bus_s1.ctrl_i = ctrl;  assign bus_s1.data_i = data;
    assign bus_s1.ready_i = rdy;    assign bus_s1.flush_i = flush; assign bus_s1.clr_cnt_i = clr;
    assign bus_s0.valid_i = valid;  assign bus_s0.ctrl_i = ctrl;  assign bus_s0.data_i = data;
    assign bus_s0.ready_i = rdy;    assign bus_s0.flush_i = flush; assign bus_s0.clr_cnt_i = clr;
    assign bus_c4.valid_i = valid;  assign bus_c4.ctrl_i = ctrl;  assign bus_c4.data_i = data;
    assign bus_c4.ready_i = rdy;    assign bus_c4.flush_i = flush; assign bus_c4.clr_cnt_i = clr;

    pipe_stage_reg #(.CTRL_W(c_cw), .DATA_W(c_dw), .SKID(1), .CTRL_CLR(c_clr), .CNT_W(16))
        u_dut_s1 (.clk_i(clk), .rst_i(rst), .bus(bus_s1));
    pipe_stage_reg #(.CTRL_W(c_cw), .DATA_W(c_dw), .SKID(0), .CTRL_CLR(c_clr), .CNT_W(16))
        u_dut_s0 (.clk_i(clk), .rst_i(rst), .bus(bus_s0));
    pipe_stage_reg #(.CTRL_W(c_cw), .DATA_W(c_dw), .SKID(1), .CTRL_CLR(c_clr), .CNT_W(4))
        u_dut_c4 (.clk_i(clk), .rst_i(rst), .bus(bus_c4));

    // Model: each variant is a FIFO of capacity 2 or 1 with saturating counters.
    logic [c_cw+c_dw-1:0] m_ent [3][2];
    int    m_size  [3] = '{0, 0, 0};
    int    m_stall [3] = '{0, 0, 0};
    int    m_flush [3] = '{0, 0, 0};
    bit    m_fresh [3] = '{1, 1, 1};
    int    m_cap   [3] = '{2, 1, 2};
    bit    m_regrdy[3] = '{1, 0, 1};
    int    m_cmax  [3] = '{65535, 65535, 15};
    string m_name  [3] = '{"s1", "s0", "c4"};

    function automatic bit m_ready(int k, bit r);
        if (m_regrdy[k]) return (m_size[k] < m_cap[k]);
        return (r || m_size[k] == 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic            ov, orr;
            logic [1:0]      oocc;
            logic [c_cw-1:0] oc;
            logic [c_dw-1:0] od;
            logic [15:0]     os, of;
            logic [c_cw-1:0] ec;
            case (k)
                0: begin ov = bus_s1.valid_o; orr = bus_s1.ready_o; oocc = bus_s1.occupancy_o;
                         oc = bus_s1.ctrl_o; od = bus_s1.data_o;
                         os = bus_s1.stall_cnt_o; of = bus_s1.flush_cnt_o; end
                1: begin ov = bus_s0.valid_o; orr = bus_s0.ready_o; oocc = bus_s0.occupancy_o;
                         oc = bus_s0.ctrl_o; od = bus_s0.data_o;
                         os = bus_s0.stall_cnt_o; of = bus_s0.flush_cnt_o; end
                default: begin ov = bus_c4.valid_o; orr = bus_c4.ready_o; oocc = bus_c4.occupancy_o;
                         oc = bus_c4.ctrl_o; od = bus_c4.data_o;
                         os = {12'd0, bus_c4.stall_cnt_o}; of = {12'd0, bus_c4.flush_cnt_o}; end
            endcase
            ec = (m_size[k] > 0) ? m_ent[k][0][c_cw+c_dw-1:c_dw] : c_clr;
            chk({m_name[k], "_valid"}, 64'(ov), 64'(m_size[k] > 0));
            chk({m_name[k], "_ready"}, 64'(orr), 64'(m_ready(k, rdy)));
            chk({m_name[k], "_occ"}, 64'(oocc), 64'(m_size[k]));
            chk({m_name[k], "_ctrl"}, 64'(oc), 64'(ec));
            if (m_size[k] > 0) chk({m_name[k], "_data"}, 64'(od), 64'(m_ent[k][0][c_dw-1:0]));
            else if (m_fresh[k]) chk({m_name[k], "_data_rst"}, 64'(od), 64'd0);
            chk({m_name[k], "_stall_cnt"}, 64'(os), 64'(m_stall[k]));
            chk({m_name[k], "_flush_cnt"}, 64'(of), 64'(m_flush[k]));
        end
    endtask

    task automatic cyc(input bit v, input logic [c_cw-1:0] c, input logic [c_dw-1:0] d,
                       input bit r, input bit f, input bit cl, input bit rs);
        bit inx [3];
        bit outx[3];
        bit stl [3];
        valid = v; ctrl = c; data = d; rdy = r; flush = f; clr = cl; rst = rs;
        for (int k = 0; k < 3; k++) begin
            inx[k]  = v && m_ready(k, r);
            outx[k] = (m_size[k] > 0) && r;
            stl[k]  = (m_size[k] > 0) && !r;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rs) begin
                m_size[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_fresh[k] = 1;
            end else begin
                if (cl) begin
                    m_stall[k] = 0; m_flush[k] = 0;
                end else begin
                    if (stl[k] && m_stall[k] < m_cmax[k]) m_stall[k]++;
                    if (f && m_flush[k] < m_cmax[k]) m_flush[k]++;
                end
                if (f) begin
                    m_size[k] = 0;
                end else begin
                    if (outx[k]) begin
                        m_ent[k][0] = m_ent[k][1];
                        m_size[k]--;
                    end
                    if (inx[k]) begin
                        m_ent[k][m_size[k]] = {c, d};
                        m_size[k]++;
                        m_fresh[k] = 0;
                    end
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset, then a back-to-back stream 1..4 and drain.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 10'(i), 32'(i), 1, 0, 0, 0);
        chk("s1_stream_last", 64'(bus_s1.data_o), 64'd4);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Stall: A then B with ready low, then release.
        cyc(1, 10'h0A, 32'hAAAA_0001, 0, 0, 0, 0);
        cyc(1, 10'h0B, 32'hBBBB_0002, 0, 0, 0, 0);
        chk("s1_skid_occ", 64'(bus_s1.occupancy_o), 64'd2);
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // Flush at occupancy 2 while C is offered.
        cyc(1, 10'h01, 32'h1111_0001, 0, 0, 0, 0);
        cyc(1, 10'h02, 32'h2222_0002, 0, 0, 0, 0);
        cyc(1, 10'h0C, 32'hCCCC_0003, 0, 1, 0, 0);
        chk("s1_first_flush_cnt", 64'(bus_s1.flush_cnt_o), 64'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // Single-entry pass-through: held output, then simultaneous D.
        cyc(1, 10'h05, 32'h5555_0005, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 10'h0D, 32'hDDDD_000D, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Counter saturation, then clear together with a stall cycle.
        cyc(1, 10'h06, 32'h6666_0006, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("c4_stall_sat", 64'(bus_c4.stall_cnt_o), 64'd15);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("c4_stall_clr", 64'(bus_c4.stall_cnt_o), 64'd0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // Reset while the skid slot is occupied, then E with latency 1.
        cyc(1, 10'h07, 32'h7777_0007, 0, 0, 0, 0);
        cyc(1, 10'h08, 32'h8888_0008, 0, 0, 0, 0);
        cyc(1, 10'h09, 32'h9999_0009, 0, 0, 0, 1);
        cyc(1, 10'h0E, 32'hEEEE_000E, 1, 0, 0, 0);
        chk("s1_after_rst_e", 64'(bus_s1.data_o), 64'hEEEE_000E);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, 10'($urandom), 32'($urandom),
                ($urandom % 3) != 0, ($urandom % 16) == 0,
                ($urandom % 32) == 0, ($urandom % 64) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
